counter4bit_sequencer: RTL and testbench
========================================

Name: counter4bit_sequencer

Overview:
- Run controller for the 4-bit 1 Hz counter display path.
- Merges the clock-divider and counter functions under one FSM: start/stop/clear/load commands, up/down direction, programmable terminal value, one-shot or auto-reload.
- Sits between the board buttons/switches (already synchronised and debounced upstream) and the 7-segment/LED output.
- Generates its own count-enable tick from clk_50M; no derived clocks.

Parameters:
- DIV, 50_000_000, clk_50M cycles per count tick; must be >= 2. Benches use 4.
- PW, $clog2(DIV), prescaler width; derived, not overridden.

Ports:
- clk_50M  input  1  system clock, 50 MHz, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle command pulse; run/resume.
- stop  input  1  single-cycle command pulse; pause.
- clear  input  1  single-cycle command pulse; return to IDLE with the start value.
- load_en  input  1  single-cycle pulse; load load_val.
- load_val  input  4  preset value.
- up_down  input  1  1 = count up, 0 = count down.
- limit  input  4  terminal value.
- auto_reload  input  1  1 = wrap at terminal, 0 = stop in DONE.
- Output  output  4  current count.
- tick  output  1  high for one cycle; count steps on the edge that ends this cycle.
- running  output  1  state == RUN.
- done  output  1  state == DONE.
- state  output  2  IDLE=00, RUN=01, PAUSE=10, DONE=11.

Behaviour:
- Reset (Reset=0, async):
  - Output=0, state=IDLE, prescaler pc=0.
  - tick, running and done all 0.
  - Release is synchronous to the next edge.
- Start value (SV): 0 when up_down=1; limit when up_down=0.
- Prescaler pc:
  - Increments each cycle only in RUN.
  - Wraps DIV-1 -> 0.
  - Forced to 0 in every other state and on any state change.
- tick: combinational decode, state==RUN && pc==DIV-1.
  - First tick occurs DIV cycles after the edge that enters RUN.
- On a tick edge, counting up:
  - If Output >= limit: auto_reload=1 -> Output<=0, stay RUN; auto_reload=0 -> Output holds, state<=DONE.
  - Otherwise Output<=Output+1.
- On a tick edge, counting down:
  - If Output==0: auto_reload=1 -> Output<=limit; auto_reload=0 -> Output holds, state<=DONE.
  - If Output > limit: Output<=limit.
  - Otherwise Output<=Output-1.
- up_down, limit and auto_reload are sampled only on tick edges. Changing them mid-run takes effect at the next tick; Output is never modified between ticks.
- Command priority, when pulses coincide: clear > load_en > stop > start. Only the highest-priority command acts; the others are dropped, not queued.
- clear (any state): Output<=SV, state<=IDLE, pc<=0.
- load_en:
  - Accepted in IDLE, PAUSE and DONE; ignored in RUN.
  - Output<=min(load_val, limit).
  - From DONE, goes to IDLE; otherwise the state is unchanged.
- stop: RUN -> PAUSE, Output held. Ignored in other states.
- start:
  - IDLE -> RUN and PAUSE -> RUN, with Output unchanged.
  - DONE -> RUN with Output<=SV.
  - Ignored in RUN.
- A command edge that coincides with a tick edge: the command wins and the tick's count step is discarded. The only exception is start, which cannot occur in RUN.
- Reset mid-run aborts immediately to the reset values. No partial tick is produced.
- All arithmetic is 4-bit. There is no carry out; wrap happens only through the rules above.

Decomposition:
- Shared package/header counter_seq_pkg holds:
  - State encodings ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE (2-bit).
  - CNT_W=4.
- One sub-module, tick_prescaler:
  - Ports: clk_50M, Reset, enable, tick.
  - Parameter: DIV.
  - Holds pc; clears when enable=0.
- Top level holds the FSM and the count register.

Test Plan (DIV=4):
- Reset low mid-run with Output=5 -> Output=0, state=00, tick=0 immediately (async). The first tick after release and start comes 4 cycles later.
- up_down=1, limit=3, auto_reload=0, start -> Output steps 0,1,2,3, one step per 4 cycles, then state=11, done=1, Output holds 3. A further start gives Output=0 and running=1.
- up_down=0, limit=9, auto_reload=1, clear then start -> Output 9,8,…,0,9. tick period is exactly 4 cycles and no DONE is entered.
- Run at Output=2, stop -> state=10 and Output stays 2 for 20 cycles. start -> the next step to 3 comes exactly 4 cycles after resume.
- In IDLE with limit=7, load_en with load_val=12 -> Output=7. load_en in RUN -> ignored.
- clear, stop and load_en in the same cycle as a tick edge -> clear wins: state=00, Output=SV, no count step.

Source files
------------

// File: rtl/counter_seq_pkg.sv
// Shared types for the 4-bit run controller: FSM state encodings, command
// decode values and the count width.
package counter_seq_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_DONE  = 2'b11
   } state_e;

   // Only the highest-priority pulse survives decode.
   typedef enum logic [2:0] {
      CMD_NONE,
      CMD_START,
      CMD_STOP,
      CMD_LOAD,
      CMD_CLEAR
   } cmd_e;

   function automatic logic [CNT_W-1:0] min_cnt(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler that raises tick for one cycle every DIV enabled
// cycles; the count is held at zero whenever enable is low.
module tick_prescaler #(
   parameter int DIV = 50_000_000
) (
   input  logic clk_50M,
   input  logic Reset,
   input  logic enable,
   output logic tick
);

   localparam int PW = $clog2(DIV);
   localparam logic [PW-1:0] PC_MAX = PW'(DIV - 1);

   logic [PW-1:0] pc_q, pc_d;

   always_comb begin
      pc_d = '0;
      if (enable)
         pc_d = (pc_q == PC_MAX) ? '0 : pc_q + PW'(1);
   end

   always_ff @(posedge clk_50M or negedge Reset) begin
      if (!Reset) pc_q <= '0;
      else        pc_q <= pc_d;
   end

   assign tick = (pc_q == PC_MAX);

endmodule

// File: rtl/counter4bit_sequencer.sv
// Run controller for the 4-bit 1 Hz counter: command FSM, count register and
// the internally generated count-enable tick.
module counter4bit_sequencer
   import counter_seq_pkg::*;
#(
   parameter int DIV = 50_000_000
) (
   input  logic             clk_50M,
   input  logic             Reset,
   input  logic             start,
   input  logic             stop,
   input  logic             clear,
   input  logic             load_en,
   input  logic [CNT_W-1:0] load_val,
   input  logic             up_down,
   input  logic [CNT_W-1:0] limit,
   input  logic             auto_reload,
   output logic [CNT_W-1:0] Output,
   output logic             tick,
   output logic             running,
   output logic             done,
   output logic [1:0]       state
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] start_val;
   logic [CNT_W-1:0] step_cnt;
   logic             step_done;
   logic             pre_tick;
   logic             pc_en;
   cmd_e             cmd;

   assign start_val = up_down ? '0 : limit;

   always_comb begin
      cmd = CMD_NONE;
      if      (clear)   cmd = CMD_CLEAR;
      else if (load_en) cmd = CMD_LOAD;
      else if (stop)    cmd = CMD_STOP;
      else if (start)   cmd = CMD_START;
   end

   // Result of a count step, evaluated only when a tick edge is taken.
   always_comb begin
      step_cnt  = cnt_q;
      step_done = 1'b0;
      if (up_down) begin
         if (cnt_q >= limit) begin
            step_cnt  = auto_reload ? '0 : cnt_q;
            step_done = !auto_reload;
         end else begin
            step_cnt = cnt_q + 1'b1;
         end
      end else begin
         if (cnt_q == '0) begin
            step_cnt  = auto_reload ? limit : cnt_q;
            step_done = !auto_reload;
         end else if (cnt_q > limit) begin
            step_cnt = limit;
         end else begin
            step_cnt = cnt_q - 1'b1;
         end
      end
   end

   // Tick step first; an acting command then overrides it entirely.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (tick) begin
         cnt_d = step_cnt;
         if (step_done) state_d = ST_DONE;
      end
      unique case (cmd)
         CMD_CLEAR: begin
            state_d = ST_IDLE;
            cnt_d   = start_val;
         end
         CMD_LOAD: begin
            if (state_q != ST_RUN) begin
               cnt_d   = min_cnt(load_val, limit);
               state_d = (state_q == ST_DONE) ? ST_IDLE : state_q;
            end
         end
         CMD_STOP: begin
            if (state_q == ST_RUN) begin
               state_d = ST_PAUSE;
               cnt_d   = cnt_q;
            end
         end
         CMD_START: begin
            if (state_q != ST_RUN) begin
               state_d = ST_RUN;
               cnt_d   = (state_q == ST_DONE) ? start_val : cnt_q;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_50M or negedge Reset) begin
      if (!Reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Prescaler runs only while staying in RUN, so it restarts on every entry.
   assign pc_en = (state_q == ST_RUN) && (state_d == ST_RUN);

   tick_prescaler #(.DIV(DIV)) u_prescaler (
      .clk_50M (clk_50M),
      .Reset   (Reset),
      .enable  (pc_en),
      .tick    (pre_tick)
   );

   assign tick    = pre_tick && (state_q == ST_RUN);
   assign Output  = cnt_q;
   assign running = (state_q == ST_RUN);
   assign done    = (state_q == ST_DONE);
   assign state   = state_q;

endmodule

// File: tb/tb_counter4bit_sequencer.sv
// Scoreboard bench: the driver pushes the reference model's expected outputs
// each cycle; a negedge monitor pops and compares them against the DUT.
module tb_counter4bit_sequencer;

   localparam int DIV = 4;

   logic       clk_50M = 1'b0;
   logic       Reset, start, stop, clear, load_en, up_down, auto_reload;
   logic [3:0] load_val, limit, Output;
   logic       tick, running, done;
   logic [1:0] state;

   always #5 clk_50M = ~clk_50M;

   counter4bit_sequencer #(.DIV(DIV)) dut (
      .clk_50M     (clk_50M),
      .Reset       (Reset),
      .start       (start),
      .stop        (stop),
      .clear       (clear),
      .load_en     (load_en),
      .load_val    (load_val),
      .up_down     (up_down),
      .limit       (limit),
      .auto_reload (auto_reload),
      .Output      (Output),
      .tick        (tick),
      .running     (running),
      .done        (done),
      .state       (state)
   );

   typedef struct {
      int cnt;
      int st;
      bit tk;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_fail = 0;

   // Reference model: st 0=IDLE 1=RUN 2=PAUSE 3=DONE, ph = cycles spent in RUN mod DIV
   int m_cnt, m_st, m_ph;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk_50M) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("sb_count", 32'(Output), e.cnt);
         chk("sb_state", 32'(state), e.st);
         chk("sb_tick", 32'(tick), 32'(e.tk));
         chk("sb_running", 32'(running), 32'(e.st == 1));
         chk("sb_done", 32'(done), 32'(e.st == 3));
      end
   end

   task automatic model_reset();
      m_cnt = 0;
      m_st  = 0;
      m_ph  = 0;
   endtask

   task automatic tick_rule(inout int nc, inout int ns);
      if (up_down) begin
         if (m_cnt >= int'(limit)) begin
            if (auto_reload) nc = 0;
            else             ns = 3;
         end else nc = m_cnt + 1;
      end else begin
         if (m_cnt == 0) begin
            if (auto_reload) nc = int'(limit);
            else             ns = 3;
         end else if (m_cnt > int'(limit)) nc = int'(limit);
         else nc = m_cnt - 1;
      end
   endtask

   task automatic model_step();
      int sv, nc, ns;
      bit tk;
      tk = (m_st == 1) && (m_ph == DIV - 1);
      sv = up_down ? 0 : int'(limit);
      nc = m_cnt;
      ns = m_st;
      if (clear) begin
         nc = sv;
         ns = 0;
      end else if (load_en) begin
         if (m_st != 1) begin
            nc = (load_val < limit) ? int'(load_val) : int'(limit);
            if (m_st == 3) ns = 0;
         end else if (tk) tick_rule(nc, ns);
      end else if (stop) begin
         if (m_st == 1) ns = 2;
      end else if (start) begin
         if (m_st == 3) begin
            nc = sv;
            ns = 1;
         end else if (m_st == 1) begin
            if (tk) tick_rule(nc, ns);
         end else ns = 1;
      end else if (tk) tick_rule(nc, ns);
      m_ph  = (m_st == 1 && ns == 1) ? (m_ph + 1) % DIV : 0;
      m_cnt = nc;
      m_st  = ns;
   endtask

   // One clock: publish expectation for the current cycle, take the edge, advance the model.
   task automatic tcycle();
      exp_t e;
      e.cnt = m_cnt;
      e.st  = m_st;
      e.tk  = (m_st == 1) && (m_ph == DIV - 1);
      q.push_back(e);
      @(posedge clk_50M);
      if (!Reset) model_reset();
      else        model_step();
      #1;
      start   = 1'b0;
      stop    = 1'b0;
      clear   = 1'b0;
      load_en = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  n, last, cyc, r, prev;
      bit  saw_done, wrapped;
      Reset = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; load_en = 1'b0;
      load_val = '0; limit = '0; up_down = 1'b1; auto_reload = 1'b0;
      model_reset();
      @(posedge clk_50M);
      #1;
      repeat (2) tcycle();

      // Asynchronous reset in the middle of a run
      Reset = 1'b1;
      limit = 4'd9; auto_reload = 1'b1; clear = 1'b1;
      tcycle();
      start = 1'b1;
      tcycle();
      n = 0;
      while (m_cnt != 5 && n < 100) begin tcycle(); n++; end
      chk("reach_count5", 32'(Output), 5);
      Reset = 1'b0;
      #1;
      chk("async_rst_count", 32'(Output), 0);
      chk("async_rst_state", 32'(state), 0);
      chk("async_rst_tick", 32'(tick), 0);
      chk("async_rst_running", 32'(running), 0);
      model_reset();
      repeat (2) tcycle();
      Reset = 1'b1;
      tcycle();
      start = 1'b1;
      tcycle();
      n = 0;
      while (!tick && n < 20) begin tcycle(); n++; end
      chk("first_tick_latency", n, DIV - 1);

      // Up count, one-shot
      up_down = 1'b1; limit = 4'd3; auto_reload = 1'b0; clear = 1'b1;
      tcycle();
      start = 1'b1;
      tcycle();
      n = 0;
      while (!done && n < 100) begin tcycle(); n++; end
      chk("up_done_latency", n, 4 * DIV);
      chk("up_done_state", 32'(state), 3);
      chk("up_done_count", 32'(Output), 3);
      repeat (6) tcycle();
      chk("done_hold", 32'(Output), 3);
      start = 1'b1;
      tcycle();
      chk("restart_count", 32'(Output), 0);
      chk("restart_running", 32'(running), 1);

      // Down count with auto-reload
      up_down = 1'b0; limit = 4'd9; auto_reload = 1'b1; clear = 1'b1;
      tcycle();
      chk("clear_sv_down", 32'(Output), 9);
      start = 1'b1;
      tcycle();
      last = -1; cyc = 0; saw_done = 0; wrapped = 0;
      for (int i = 0; i < 12 * DIV; i++) begin
         prev = int'(Output);
         tcycle();
         cyc++;
         if (tick) begin
            if (last >= 0) chk("tick_period", cyc - last, DIV);
            last = cyc;
         end
         if (done) saw_done = 1;
         if (prev == 0 && Output == 4'd9) wrapped = 1;
      end
      chk("down_no_done", 32'(saw_done), 0);
      chk("down_wrap_0_to_9", 32'(wrapped), 1);

      // Pause and resume
      up_down = 1'b1; limit = 4'd9; auto_reload = 1'b1; clear = 1'b1;
      tcycle();
      start = 1'b1;
      tcycle();
      n = 0;
      while (Output != 4'd2 && n < 100) begin tcycle(); n++; end
      stop = 1'b1;
      tcycle();
      chk("pause_state", 32'(state), 2);
      for (int i = 0; i < 20; i++) begin
         tcycle();
         chk("pause_hold", 32'(Output), 2);
      end
      start = 1'b1;
      tcycle();
      n = 0;
      while (Output != 4'd3 && n < 20) begin tcycle(); n++; end
      chk("resume_step", n, DIV);

      // Load saturates at limit in IDLE, is ignored in RUN
      clear = 1'b1;
      tcycle();
      limit = 4'd7; load_en = 1'b1; load_val = 4'd12;
      tcycle();
      chk("load_clamped", 32'(Output), 7);
      chk("load_idle_state", 32'(state), 0);
      start = 1'b1;
      tcycle();
      load_en = 1'b1; load_val = 4'd1;
      tcycle();
      chk("load_in_run_ignored", 32'(Output), 7);
      chk("load_in_run_state", 32'(state), 1);

      // clear + stop + load on a tick edge
      limit = 4'd9; clear = 1'b1;
      tcycle();
      start = 1'b1;
      tcycle();
      repeat (5) tcycle();
      n = 0;
      while (!tick && n < 20) begin tcycle(); n++; end
      clear = 1'b1; stop = 1'b1; load_en = 1'b1; load_val = 4'd5;
      tcycle();
      chk("coincide_state", 32'(state), 0);
      chk("coincide_count", 32'(Output), 0);

      // Randomised traffic
      for (int i = 0; i < 1500; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 4) begin
            clear = 1'b1;
            stop = 1'($urandom); load_en = 1'($urandom); start = 1'($urandom);
            load_val = 4'($urandom);
         end else if (r < 8 && m_st != 1) begin
            load_en = 1'b1; load_val = 4'($urandom);
         end else if (r < 12) stop = 1'b1;
         else if (r < 20) start = 1'b1;
         if ($urandom_range(0, 15) == 0) begin
            up_down = 1'($urandom); limit = 4'($urandom); auto_reload = 1'($urandom);
         end
         tcycle();
      end

      chk("sb_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
